// File: rtl/ethernet_transmit_framer_if.sv
// Byte-stream input and line-side output bundle of the Ethernet transmit framer.
// The framer binds to the slave modport; the stream source binds to master.
interface ethernet_transmit_framer_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic [7:0] tx_data;
    logic       tx_enable;
    logic       tx_error;
    logic       busy;

    modport master (
        output s_data, s_valid, s_last,
        input  s_ready, tx_data, tx_enable, tx_error, busy
    );

    modport slave (
        input  s_data, s_valid, s_last,
        output s_ready, tx_data, tx_enable, tx_error, busy
    );
endinterface

// File: rtl/ethernet_transmit_framer.sv
// Ethernet transmit framer: preamble/SFD, payload, optional pad, CRC-32 FCS, IFG.
// Define FRAME_PADDING_EN to pad short frames to 60 payload+pad bytes.
module ethernet_transmit_framer (
    input  logic clock,
    input  logic reset_n,
    ethernet_transmit_framer_if.slave bus
);
    localparam logic [31:0] POLY    = 32'hEDB88320;
    localparam logic [10:0] MAX_LEN = 11'd1514;
`ifdef FRAME_PADDING_EN
    localparam logic [10:0] MIN_LEN = 11'd60;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SFD,
        S_PAYLOAD,
        S_PAD,
        S_FCS,
        S_DROP,
        S_GAP
    } state_t;

    state_t      state_q;
    logic [2:0]  pre_cnt_q;
    logic [10:0] byte_cnt_q;
    logic [2:0]  fcs_cnt_q;
    logic [3:0]  gap_cnt_q;
    logic [31:0] crc_q;
    logic [7:0]  tx_data_q;
    logic        tx_enable_q;
    logic        tx_error_q;

    logic        accept;
    logic [10:0] byte_cnt_d;
    logic [31:0] crc_d;
    logic [31:0] fcs;
    logic [7:0]  fcs_byte;
`ifdef FRAME_PADDING_EN
    logic [31:0] crc_pad_d;
`endif

    function automatic logic [31:0] crc_byte(
        input logic [31:0] c,
        input logic [7:0]  d
    );
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ POLY) : (r >> 1);
        end
        return r;
    endfunction

    // Ready is a pure decode of the registered state.
    assign bus.s_ready   = (state_q == S_SFD) ||
                           (state_q == S_PAYLOAD) ||
                           (state_q == S_DROP);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_enable = tx_enable_q;
    assign bus.tx_error  = tx_error_q;

    assign accept     = bus.s_valid & bus.s_ready;
    assign byte_cnt_d = byte_cnt_q + 11'd1;
    assign crc_d      = crc_byte(crc_q, bus.s_data);
    assign fcs        = ~crc_q;
`ifdef FRAME_PADDING_EN
    assign crc_pad_d  = crc_byte(crc_q, 8'h00);
`endif

    always_comb begin
        fcs_byte = fcs[7:0];
        unique case (fcs_cnt_q[1:0])
            2'd0: fcs_byte = fcs[7:0];
            2'd1: fcs_byte = fcs[15:8];
            2'd2: fcs_byte = fcs[23:16];
            2'd3: fcs_byte = fcs[31:24];
        endcase
    end

    // Outputs are registered one state ahead: each state loads what
    // the line shows in the following cycle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            pre_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            fcs_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            crc_q       <= '1;
            tx_data_q   <= '0;
            tx_enable_q <= 1'b0;
            tx_error_q  <= 1'b0;
        end else begin
            tx_error_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    pre_cnt_q   <= '0;
                    byte_cnt_q  <= '0;
                    fcs_cnt_q   <= '0;
                    gap_cnt_q   <= '0;
                    crc_q       <= '1;
                    tx_data_q   <= '0;
                    tx_enable_q <= 1'b0;
                    if (bus.s_valid) begin
                        state_q     <= S_PREAMBLE;
                        tx_data_q   <= 8'h55;
                        tx_enable_q <= 1'b1;
                    end
                end
                S_PREAMBLE: begin
                    if (pre_cnt_q == 3'd6) begin
                        state_q   <= S_SFD;
                        tx_data_q <= 8'hD5;
                    end else begin
                        pre_cnt_q <= pre_cnt_q + 3'd1;
                    end
                end
                S_SFD, S_PAYLOAD: begin
                    if (!accept || (!bus.s_last && byte_cnt_d == MAX_LEN)) begin
                        state_q     <= S_DROP;
                        tx_error_q  <= 1'b1;
                        tx_enable_q <= 1'b0;
                        tx_data_q   <= '0;
                    end else begin
                        byte_cnt_q <= byte_cnt_d;
                        crc_q      <= crc_d;
                        tx_data_q  <= bus.s_data;
                        fcs_cnt_q  <= '0;
                        if (bus.s_last) begin
`ifdef FRAME_PADDING_EN
                            state_q <= (byte_cnt_d < MIN_LEN) ? S_PAD : S_FCS;
`else
                            state_q <= S_FCS;
`endif
                        end else begin
                            state_q <= S_PAYLOAD;
                        end
                    end
                end
`ifdef FRAME_PADDING_EN
                S_PAD: begin
                    if (byte_cnt_q == MIN_LEN) begin
                        state_q   <= S_FCS;
                        tx_data_q <= fcs_byte;
                        fcs_cnt_q <= 3'd1;
                    end else begin
                        byte_cnt_q <= byte_cnt_d;
                        crc_q      <= crc_pad_d;
                        tx_data_q  <= 8'h00;
                    end
                end
`endif
                S_FCS: begin
                    if (fcs_cnt_q == 3'd4) begin
                        state_q     <= S_GAP;
                        gap_cnt_q   <= '0;
                        tx_enable_q <= 1'b0;
                        tx_data_q   <= '0;
                    end else begin
                        tx_data_q <= fcs_byte;
                        fcs_cnt_q <= fcs_cnt_q + 3'd1;
                    end
                end
                S_DROP: begin
                    if (accept && bus.s_last) begin
                        state_q   <= S_GAP;
                        gap_cnt_q <= '0;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == 4'd11) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    tx_enable_q <= 1'b0;
                    tx_data_q   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ethernet_transmit_framer.sv
// Directed bench for the Ethernet transmit framer (table of frames plus
// hand-written underrun, oversize and mid-frame reset sequences).
module tb_ethernet_transmit_framer;
    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    ethernet_transmit_framer_if bus();

    ethernet_transmit_framer dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int          len;
        logic [7:0]  seed;
        logic [7:0]  step;
        int          exp_run;
        bit          has_fcs;
        logic [31:0] fcs;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic       rec = 1'b0;
    logic       lg_en[$];
    logic [7:0] lg_dat[$];
    logic       lg_err[$];
    logic       lg_busy[$];

    always @(negedge clock) begin
        if (rec) begin
            lg_en.push_back(bus.tx_enable);
            lg_dat.push_back(bus.tx_data);
            lg_err.push_back(bus.tx_error);
            lg_busy.push_back(bus.busy);
        end
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Non-reflected MSB-first CRC on bit-reversed input, reflected at the end.
    function automatic logic [31:0] ref_fcs(input logic [7:0] b[$]);
        logic [31:0] c;
        logic [31:0] r;
        logic        m;
        c = '1;
        foreach (b[k]) begin
            for (int i = 0; i < 8; i++) begin
                m = c[31] ^ b[k][i];
                c = c << 1;
                if (m) c = c ^ 32'h04C11DB7;
            end
        end
        for (int i = 0; i < 32; i++) r[i] = c[31-i];
        return ~r;
    endfunction

    function automatic void mk_payload(input int len, input logic [7:0] seed,
                                       input logic [7:0] step,
                                       output logic [7:0] q[$]);
        q = {};
        for (int i = 0; i < len; i++) q.push_back(8'(seed + 8'(i) * step));
    endfunction

    function automatic void build_exp(input logic [7:0] pl[$],
                                      output logic [7:0] e[$]);
        logic [7:0]  body[$];
        logic [31:0] f;
        e = {};
        body = pl;
`ifdef FRAME_PADDING_EN
        while (body.size() < 60) body.push_back(8'h00);
`endif
        f = ref_fcs(body);
        repeat (7) e.push_back(8'h55);
        e.push_back(8'hD5);
        foreach (body[k]) e.push_back(body[k]);
        for (int i = 0; i < 4; i++) e.push_back(f[8*i +: 8]);
    endfunction

    // Entered and left just after a rising edge.
    task automatic send(input string nm, input logic [7:0] pl[$],
                        input int hole_at, input int hole_len);
        int   idx;
        int   hole;
        int   budget;
        logic rdy;
        idx = 0;
        hole = 0;
        budget = 0;
        while (idx < pl.size() && budget < 5000) begin
            if (idx == hole_at && hole < hole_len) begin
                bus.s_valid = 1'b0;
                bus.s_last  = 1'b0;
                hole++;
            end else begin
                bus.s_valid = 1'b1;
                bus.s_data  = pl[idx];
                bus.s_last  = (idx == pl.size() - 1);
            end
            @(negedge clock);
            rdy = bus.s_ready;
            @(posedge clock);
            if (bus.s_valid && rdy) idx++;
            #1;
            budget++;
        end
        check({nm, " drv_done"}, 32'(idx), 32'(pl.size()));
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.s_data  = 8'h00;
    endtask

    task automatic analyze(input string nm, input logic [7:0] e[$],
                           input int exp_run, input bit exp_err,
                           output logic [31:0] obs_fcs);
        int first;
        int run;
        int mism;
        int errs;
        int err_at;
        int dirty;
        int gapbad;
        int stop;
        int sz;
        first = -1;
        run = 0;
        mism = 0;
        errs = 0;
        err_at = -1;
        dirty = 0;
        gapbad = 0;
        sz = lg_en.size();
        for (int k = 0; k < sz; k++) begin
            if (first < 0 && lg_en[k]) first = k;
            if (lg_err[k]) begin
                errs++;
                if (err_at < 0) err_at = k;
            end
            if (!lg_en[k] && lg_dat[k] !== 8'h00) dirty++;
        end
        if (first < 0) first = sz;
        while (first + run < sz && lg_en[first+run]) run++;
        stop = first + run;
        check({nm, " run"}, 32'(run), 32'(exp_run));
        for (int i = 0; i < run && i < e.size(); i++)
            if (lg_dat[first+i] !== e[i]) mism++;
        check({nm, " bytes"}, 32'(mism), 32'd0);
        check({nm, " idle_zero"}, 32'(dirty), 32'd0);
        obs_fcs = '0;
        if (run >= 4)
            for (int i = 0; i < 4; i++) obs_fcs[8*i +: 8] = lg_dat[stop-4+i];
        if (exp_err) begin
            check({nm, " err_cnt"}, 32'(errs), 32'd1);
            check({nm, " err_pos"}, 32'(err_at), 32'(stop));
        end else begin
            check({nm, " err_cnt"}, 32'(errs), 32'd0);
            for (int i = 0; i < 12; i++)
                if (stop + i >= sz || lg_busy[stop+i] !== 1'b1 ||
                    lg_en[stop+i] !== 1'b0) gapbad++;
            if (stop + 12 >= sz || lg_busy[stop+12] !== 1'b0) gapbad++;
            check({nm, " gap"}, 32'(gapbad), 32'd0);
        end
    endtask

    task automatic run_frame(input string nm, input logic [7:0] pl[$],
                             input int hole_at, input int hole_len,
                             input int exp_run, input bit exp_err,
                             output logic [31:0] obs_fcs);
        logic [7:0] e[$];
        build_exp(pl, e);
        lg_en.delete();
        lg_dat.delete();
        lg_err.delete();
        lg_busy.delete();
        rec = 1'b1;
        send(nm, pl, hole_at, hole_len);
        repeat (100) @(posedge clock);
        #1;
        rec = 1'b0;
        analyze(nm, e, exp_run, exp_err, obs_fcs);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tv[7];
        logic [7:0]  pl[$];
        logic [31:0] obs;

`ifdef FRAME_PADDING_EN
        tv[0] = '{9,   8'h31, 8'd1,  72,  1'b0, 32'h0};
        tv[1] = '{10,  8'hA0, 8'd3,  72,  1'b0, 32'h0};
        tv[2] = '{60,  8'h00, 8'd1,  72,  1'b0, 32'h0};
        tv[3] = '{1,   8'h5A, 8'd0,  72,  1'b0, 32'h0};
        tv[4] = '{59,  8'hFF, 8'd5,  72,  1'b0, 32'h0};
        tv[5] = '{61,  8'h11, 8'd11, 73,  1'b0, 32'h0};
        tv[6] = '{100, 8'h80, 8'd7,  112, 1'b0, 32'h0};
`else
        tv[0] = '{9,   8'h31, 8'd1,  21,  1'b1, 32'hCBF43926};
        tv[1] = '{10,  8'hA0, 8'd3,  22,  1'b0, 32'h0};
        tv[2] = '{60,  8'h00, 8'd1,  72,  1'b0, 32'h0};
        tv[3] = '{1,   8'h5A, 8'd0,  13,  1'b0, 32'h0};
        tv[4] = '{59,  8'hFF, 8'd5,  71,  1'b0, 32'h0};
        tv[5] = '{61,  8'h11, 8'd11, 73,  1'b0, 32'h0};
        tv[6] = '{100, 8'h80, 8'd7,  112, 1'b0, 32'h0};
`endif

        reset_n     = 1'b0;
        bus.s_data  = 8'h00;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst tx_data", 32'(bus.tx_data), 32'd0);
        check("rst tx_enable", 32'(bus.tx_enable), 32'd0);
        check("rst tx_error", 32'(bus.tx_error), 32'd0);
        check("rst s_ready", 32'(bus.s_ready), 32'd0);
        check("rst busy", 32'(bus.busy), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check("idle busy", 32'(bus.busy), 32'd0);
        check("idle s_ready", 32'(bus.s_ready), 32'd0);
        @(posedge clock);
        #1;

        for (int i = 0; i < 7; i++) begin
            mk_payload(tv[i].len, tv[i].seed, tv[i].step, pl);
            run_frame($sformatf("vec%0d", i), pl, -1, 0,
                      tv[i].exp_run, 1'b0, obs);
            if (tv[i].has_fcs)
                check($sformatf("vec%0d fcs", i), obs, tv[i].fcs);
        end

        mk_payload(20, 8'h40, 8'd1, pl);
        run_frame("underrun", pl, 5, 3, 13, 1'b1, obs);
        mk_payload(tv[1].len, tv[1].seed, tv[1].step, pl);
        run_frame("after_underrun", pl, -1, 0, tv[1].exp_run, 1'b0, obs);

        mk_payload(1515, 8'h00, 8'd1, pl);
        run_frame("oversize", pl, -1, 0, 1521, 1'b1, obs);
        mk_payload(1514, 8'h07, 8'd3, pl);
        run_frame("max_frame", pl, -1, 0, 1526, 1'b0, obs);

        mk_payload(60, 8'h3C, 8'd9, pl);
        fork
            send("rstfcs", pl, -1, 0);
            begin
                int n;
                n = 0;
                for (int c = 0; c < 400 && n < 70; c++) begin
                    @(negedge clock);
                    if (bus.tx_enable) n++;
                end
                check("rstfcs reach", 32'(n), 32'd70);
                reset_n = 1'b0;
            end
        join
        @(negedge clock);
        check("rstfcs tx_enable", 32'(bus.tx_enable), 32'd0);
        check("rstfcs busy", 32'(bus.busy), 32'd0);
        check("rstfcs tx_data", 32'(bus.tx_data), 32'd0);
        check("rstfcs tx_error", 32'(bus.tx_error), 32'd0);
        check("rstfcs s_ready", 32'(bus.s_ready), 32'd0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        mk_payload(tv[0].len, tv[0].seed, tv[0].step, pl);
        run_frame("after_rst", pl, -1, 0, tv[0].exp_run, 1'b0, obs);
        if (tv[0].has_fcs) check("after_rst fcs", obs, tv[0].fcs);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ethernet_transmit_framer.md
ETHERNET_TRANSMIT_FRAMER -- requirements
Module: ethernet_transmit_framer

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-low (ports clock, reset_n).
REQ-002 clock  input  1  rising-edge system clock for all state.
REQ-003 reset_n  input  1  synchronous active-low reset.
REQ-004 s_data  input  8  payload byte: destination MAC first, through end of payload.
REQ-005 s_valid  input  1  s_data valid.
REQ-006 s_last  input  1  marks final payload byte of the frame.
REQ-007 s_ready  output  1  byte accepted on a clock edge where s_valid and s_ready are both high.
REQ-008 tx_data  output  8  byte to PHY/MAC line.
REQ-009 tx_enable  output  1  tx_data valid, contiguous for the whole frame.
REQ-010 tx_error  output  1  one-cycle pulse; current frame aborted.
REQ-011 busy  output  1  high in every state except S_IDLE.

Function
REQ-012 States: S_IDLE, S_PREAMBLE, S_SFD, S_PAYLOAD, S_PAD, S_FCS, S_DROP, S_GAP.
REQ-013 S_IDLE: s_ready=0, tx_enable=0; s_valid=1 moves to S_PREAMBLE; the byte is not consumed.
REQ-014 S_PREAMBLE: tx_data=0x55, tx_enable=1 for exactly 7 cycles, 3-bit counter; then S_SFD.
REQ-015 S_SFD: tx_data=0xD5 for 1 cycle; s_ready=1 in this cycle so the first payload byte appears on tx_data in the cycle right after the SFD.
REQ-016 S_PAYLOAD: s_ready=1; each accepted byte is registered and driven on tx_data with tx_enable=1 one cycle after acceptance (1-cycle latency).
REQ-017 Payload byte counter 11 bits, counts accepted bytes, cleared in S_IDLE.
REQ-018 Accepted byte with s_last=1: next state S_PAD if count < 60 (pad enabled), else S_FCS; s_ready=0 from that point.
REQ-019 S_PAD: tx_data=0x00 until total of payload+pad = 60 bytes; then S_FCS.
REQ-020 CRC-32 runs internally: reflected poly 0xEDB88320, init 0xFFFFFFFF, LSB-first per byte, over every payload and pad byte (not preamble/SFD); FCS = ~CRC.
REQ-021 S_FCS: 4 bytes FCS[7:0], [15:8], [23:16], [31:24] on consecutive cycles with tx_enable=1, no gap after last payload/pad byte; then S_GAP.
REQ-022 S_GAP: tx_enable=0, s_ready=0 for exactly 12 cycles (inter-frame gap); then S_IDLE.
REQ-023 Underrun: s_valid=0 in any S_PAYLOAD cycle -> tx_error=1 for one cycle, tx_enable=0 from that cycle, go to S_DROP.
REQ-024 Oversize: byte 1514 accepted without s_last -> same abort as REQ-023.
REQ-025 S_DROP: s_ready=1, discard bytes until a byte with s_last=1 is accepted (inclusive); then S_GAP.
REQ-026 s_last together with underrun is impossible (s_valid=0); s_last on byte 1514 is legal, not oversize.
REQ-027 tx_data=0x00 whenever tx_enable=0.
REQ-028 s_ready is a registered-state decode; no combinational path from s_valid to s_ready.

Reset
REQ-029 reset_n=0: state S_IDLE, counters 0, CRC 0xFFFFFFFF, tx_data=0x00, tx_enable=0, tx_error=0, s_ready=0, busy=0.
REQ-030 Reset mid-frame aborts immediately with no tx_error pulse; first cycle after release is S_IDLE.

Configuration
REQ-031 Macro FRAME_PADDING_EN defined: S_PAD active, minimum payload+pad 60 bytes, wire frame minimum 72 bytes incl. preamble/SFD/FCS.
REQ-032 FRAME_PADDING_EN undefined: S_PAD absent; s_last goes straight to S_FCS, short frames sent unpadded.

Verification
REQ-033 Pad off, payload ASCII "123456789", s_valid held -> 0x55 x7, 0xD5, 31..39, FCS 0x26 0x39 0xF4 0xCB, 12 idle cycles.
REQ-034 Pad on, 10-byte payload -> 10 bytes, 50 x 0x00, 4 FCS bytes; tx_enable high 72 consecutive cycles.
REQ-035 Pad on, 60-byte payload -> no pad bytes; FCS immediately after byte 60.
REQ-036 s_valid dropped after payload byte 5 -> tx_error 1 cycle, tx_enable low, bytes discarded to s_last, 12-cycle gap, then next frame transmits correctly.
REQ-037 1515-byte stream -> abort at byte 1514; exactly 1514-byte frame with s_last -> sent with valid FCS.
REQ-038 reset_n low during S_FCS -> next cycle tx_enable=0, busy=0; following frame FCS correct (CRC reinitialised).
